// File: rtl/fg_classifier.sv
// Per-pixel foreground classifier.
// Three-stage pipeline: |I - E| and SD floor, K_SIGMA scaling, strict compare.
// Tracks raster position and, when FG_ALARM_EN is defined, counts foreground
// pixels per frame and raises a motion alarm at frame end. With FG_ALARM_EN
// undefined, motion_count and alarm are tied to zero.
module fg_classifier #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned HEIGHT       = 4,
  parameter logic [31:0] K_SIGMA      = 32'h0002_0000,
  parameter logic [31:0] MIN_SD       = 32'h0000_4000,
  parameter int unsigned ALARM_THRESH = 2,
  localparam int unsigned NPIX        = WIDTH * HEIGHT,
  localparam int unsigned IDX_W       = (NPIX > 1) ? $clog2(NPIX) : 1,
  localparam int unsigned CNT_W       = $clog2(NPIX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [7:0]       I_R,
  input  logic [7:0]       I_G,
  input  logic [7:0]       I_B,
  input  logic [31:0]      E_R,
  input  logic [31:0]      E_G,
  input  logic [31:0]      E_B,
  input  logic [31:0]      SD_R,
  input  logic [31:0]      SD_G,
  input  logic [31:0]      SD_B,
  output logic             valid_out,
  output logic             fg,
  output logic [IDX_W-1:0] pix_idx,
  output logic             frame_done,
  output logic [CNT_W-1:0] motion_count,
  output logic             alarm
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NPIX - 1);

  // |{pix,16'h0} - mean| in 33 bits; both operands zero-extended first.
  function automatic logic [32:0] abs_diff(input logic [7:0] pix, input logic [31:0] mean);
    logic [32:0] a;
    logic [32:0] b;
    a = {9'd0, pix, 16'd0};
    b = {1'b0, mean};
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // ---------------------------------------------------------------------------
  // Input raster index
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] in_idx_q;

  // Advance on every accepted sample; gaps do not disturb frame position.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_idx_q <= '0;
    end else if (valid_in) begin
      in_idx_q <= (in_idx_q == LastIdx) ? '0 : in_idx_q + IDX_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: absolute deviation and SD floor
  // ---------------------------------------------------------------------------
  logic [2:0][7:0]  pix_c;
  logic [2:0][31:0] mean_c;
  logic [2:0][31:0] sd_c;
  logic [2:0][32:0] d1_c;
  logic [2:0][31:0] s1_c;

  // Per-channel deviation and floored SD.
  always_comb begin
    pix_c  = {I_B, I_G, I_R};
    mean_c = {E_B, E_G, E_R};
    sd_c   = {SD_B, SD_G, SD_R};
    d1_c   = '0;
    s1_c   = '0;
    for (int c = 0; c < 3; c++) begin
      d1_c[c] = abs_diff(pix_c[c], mean_c[c]);
      s1_c[c] = (sd_c[c] > MIN_SD) ? sd_c[c] : MIN_SD;
    end
  end

  logic             v1_q;
  logic [IDX_W-1:0] idx1_q;
  logic [2:0][32:0] d1_q;
  logic [2:0][31:0] s1_q;

  // Stage 1 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      idx1_q <= '0;
      d1_q   <= '0;
      s1_q   <= '0;
    end else begin
      v1_q   <= valid_in;
      idx1_q <= in_idx_q;
      d1_q   <= d1_c;
      s1_q   <= s1_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: threshold t = (K_SIGMA * s) >> 16, kept at 48 bits
  // ---------------------------------------------------------------------------
  logic [2:0][47:0] t2_c;

  // The full 64-bit product shifted right by 16 always fits in 48 bits.
  always_comb begin
    t2_c = '0;
    for (int c = 0; c < 3; c++) begin
      t2_c[c] = 48'((64'(K_SIGMA) * 64'(s1_q[c])) >> 16);
    end
  end

  logic             v2_q;
  logic [IDX_W-1:0] idx2_q;
  logic [2:0][32:0] d2_q;
  logic [2:0][47:0] t2_q;

  // Stage 2 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q   <= 1'b0;
      idx2_q <= '0;
      d2_q   <= '0;
      t2_q   <= '0;
    end else begin
      v2_q   <= v1_q;
      idx2_q <= idx1_q;
      d2_q   <= d1_q;
      t2_q   <= t2_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: strict compare and output register
  // ---------------------------------------------------------------------------
  logic [2:0] fg_ch;
  logic       fg_any;

  // d == t counts as background.
  always_comb begin
    fg_ch = '0;
    for (int c = 0; c < 3; c++) begin
      fg_ch[c] = {15'd0, d2_q[c]} > t2_q[c];
    end
    fg_any = |fg_ch;
  end

  // Output register; fg is forced low on bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out  <= 1'b0;
      fg         <= 1'b0;
      pix_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= v2_q;
      fg         <= v2_q & fg_any;
      pix_idx    <= idx2_q;
      frame_done <= v2_q && (idx2_q == LastIdx);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame accumulator and motion alarm
  // ---------------------------------------------------------------------------
`ifdef FG_ALARM_EN
  localparam logic [31:0] Thresh = 32'(ALARM_THRESH);

  logic [CNT_W-1:0] acc_q;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] total;

  // Running count including the current output pixel, saturated at NPIX.
  always_comb begin
    sum   = {1'b0, acc_q} + (CNT_W + 1)'(fg);
    total = (32'(sum) > NPIX) ? CNT_W'(NPIX) : sum[CNT_W-1:0];
  end

  // The last pixel's fg lands in the latched count while acc clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      motion_count <= '0;
      alarm        <= 1'b0;
    end else if (valid_out) begin
      if (pix_idx == LastIdx) begin
        motion_count <= total;
        alarm        <= 32'(total) >= Thresh;
        acc_q        <= '0;
      end else begin
        acc_q <= total;
      end
    end
  end
`else
  assign motion_count = '0;
  assign alarm        = 1'b0;
`endif

endmodule

// File: doc/fg_classifier.md
# fg_classifier

Per-pixel foreground classifier that sits directly downstream of the background-model stage. Each cycle it takes a live RGB pixel with that pixel's background mean and standard deviation (Q16.16), and flags it as foreground when any channel deviates from its mean by more than K_SIGMA standard deviations. It also tracks frame position, counts foreground pixels per frame and raises a motion alarm at frame end. It feeds the mask/overlay and alarm logic of the motion-sentry pipeline.

## Interface
Parameters:
- WIDTH, 4: image width in pixels
- HEIGHT, 4: image height in pixels
- K_SIGMA, 32'h0002_0000: threshold multiplier, unsigned Q16.16 (2.0)
- MIN_SD, 32'h0000_4000: floor applied to SD before scaling, Q16.16 (0.25)
- ALARM_THRESH, 2: foreground-pixel count per frame that raises alarm

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- valid_in  in  1  input sample valid
- I_R, I_G, I_B  in  8 each  live pixel, unsigned integer
- E_R, E_G, E_B  in  32 each  background mean, unsigned Q16.16
- SD_R, SD_G, SD_B  in  32 each  background std-dev, unsigned Q16.16
- valid_out  out  1  output sample valid
- fg  out  1  foreground flag for the current output pixel
- pix_idx  out  $clog2(WIDTH*HEIGHT)  raster index of the output pixel
- frame_done  out  1  one-cycle pulse, aligned with the last pixel of a frame
- motion_count  out  $clog2(WIDTH*HEIGHT+1)  foreground count of the last completed frame
- alarm  out  1  motion_count >= ALARM_THRESH, held until the next frame_done

## Operation
- No backpressure. The pipeline advances every cycle and invalid samples propagate as bubbles.
- Stage 1: per channel, compute d = |{I,16'h0} - E| as 33-bit unsigned, and s = max(SD, MIN_SD). Register d, s, valid, and the index.
- Stage 2: per channel, compute t = (K_SIGMA * s) >> 16. The product is 64-bit; t is kept at 48 bits, so there is no truncation. Register t, d, valid, and the index.
- Stage 3: fg_c = (d > t), using a zero-extended compare. fg = fg_R | fg_G | fg_B. Register the outputs.
- Input index counter: 0..WIDTH*HEIGHT-1, incremented on each valid_in, wraps to 0 after the last pixel. It travels with the sample as pix_idx.
- Frame accumulator (FG_ALARM_EN only):
  - acc increments on each valid output with fg=1.
  - On the valid output with pix_idx = last, set motion_count <= acc + fg and alarm <= (acc + fg) >= ALARM_THRESH, then clear acc to 0.
  - acc saturates at WIDTH*HEIGHT.
- The last pixel's fg is always included in that frame's count, even though the count latches and acc clears in the same cycle.
- Reset values: valid_out=0, fg=0, pix_idx=0, frame_done=0, motion_count=0, alarm=0, index counter=0, acc=0, all pipeline valid bits 0.
- Reset mid-frame discards in-flight samples. The next valid_in is treated as pixel 0.
- d = t exactly is background: the compare is strict.
- SD=0 with I=E gives fg=0. SD=0 with |I-E| > K_SIGMA*MIN_SD gives fg=1.

## Timing
- Latency: valid_in at cycle n produces valid_out, fg and pix_idx at cycle n+3. The pipeline accepts one pixel per clock.
- frame_done is high in the same cycle as valid_out for pix_idx = WIDTH*HEIGHT-1, and is low otherwise.
- motion_count and alarm update one cycle after that frame_done, i.e. they are visible from n+4.
- Gaps in valid_in do not reset frame position.
- rst takes effect at the next clk edge. Outputs are at their reset values in the cycle after rst is sampled high.

## Configuration
- FG_ALARM_EN defined: the frame accumulator, motion_count and alarm are implemented as described above.
- FG_ALARM_EN undefined: no accumulator is built. motion_count is tied to 0 and alarm to 0. fg, pix_idx, frame_done and latency are unchanged.

## Test plan
- Defaults; E=100.0, SD=4.0, I=108 on all channels → d=8.0 equals t=8.0, so fg=0. With I=109 → fg=1 at exactly 3 cycles after valid_in.
- SD=0, E=50.0, I=50 → fg=0. I=51 (d=1.0 > t=0.5) → fg=1, which checks the MIN_SD floor.
- Only the B channel deviates: R,G at mean, I_B=200 with E_B=10.0, SD_B=1.0 → fg=1.
- A 16-pixel frame with fg on pixels 3 and 15 → frame_done pulses with pix_idx=15, then motion_count=2 and alarm=1. The next frame with fg only on pixel 0 → motion_count=1, alarm=0.
- valid_in toggling 1/0 across a frame → pix_idx stays contiguous 0..15 on valid outputs, and exactly one frame_done occurs.
- rst asserted at input pixel 7 with 3 samples in flight → no valid_out after reset until 3 cycles after the next valid_in, whose pix_idx=0. motion_count=0.
